// File: rtl/rotation_pkg.sv
// Shared types and helpers for the swerve rotation scheduler.
// Angles are 12-bit encoder counts that wrap at 4096.
package rotation_pkg;

    localparam int ANGLE_W   = 12;
    localparam int ANGLE_MOD = 4096;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ACTIVE,
        ABORTING
    } ch_state_t;

    // Shortest way round the circle between two angles (0..2048).
    function automatic logic [ANGLE_W:0] circ_dist(
        input logic [ANGLE_W-1:0] a,
        input logic [ANGLE_W-1:0] b
    );
        logic [ANGLE_W-1:0] diff;
        logic [ANGLE_W:0]   fwd;
        logic [ANGLE_W:0]   rev;
        diff = a - b;
        fwd  = {1'b0, diff};
        rev  = (ANGLE_W+1)'(ANGLE_MOD) - fwd;
        return (fwd <= rev) ? fwd : rev;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin single grant per cycle; search begins at the pointer,
// which moves to one past the winner after each grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW:0]   idx;
    logic          found;

    // Pick the first requester at or after the pointer, wrapping once
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (en_i && !found && req_i[idx[PW-1:0]]) begin
                found                = 1'b1;
                gnt_o[idx[PW-1:0]]   = 1'b1;
                ptr_d = (idx[PW-1:0] == PW'(N - 1)) ? '0
                      : idx[PW-1:0] + 1'b1;
            end
        end
    end

    // Pointer register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rotation_scheduler.sv
// Sequences per-wheel rotation moves under a concurrent-move cap,
// with skip-if-close, timeout abort and per-channel status.
module rotation_scheduler
    import rotation_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int MAX_ACTIVE = 2,
    parameter int TOL        = 5,
    parameter int TO_W       = 24
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         tgt_wr_i,
    input  logic [ANGLE_W*NUM_CH-1:0] tgt_angle_i,
    input  logic [ANGLE_W*NUM_CH-1:0] cur_angle_i,
    input  logic [TO_W-1:0]           timeout_cycles_i,
    input  logic                      abort_all_i,
    input  logic                      err_clr_i,
    input  logic [NUM_CH-1:0]         angle_done_i,
    output logic [ANGLE_W*NUM_CH-1:0] target_angle_o,
    output logic [NUM_CH-1:0]         angle_update_o,
    output logic [NUM_CH-1:0]         abort_angle_o,
    output logic [NUM_CH-1:0]         busy_o,
    output logic [NUM_CH-1:0]         done_evt_o,
    output logic [NUM_CH-1:0]         timeout_err_o
);

    logic [NUM_CH-1:0] pend_v;
    logic [NUM_CH-1:0] run_v;
    logic [NUM_CH-1:0] gnt;
    int                act_cnt_d;
    logic              grant_en_d;

    // Count channels currently holding a supply slot
    always_comb begin
        act_cnt_d = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            act_cnt_d = act_cnt_d + (run_v[k] ? 1 : 0);
        end
        grant_en_d = (act_cnt_d < MAX_ACTIVE) && !abort_all_i;
    end

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req_i   (pend_v),
        .en_i    (grant_en_d),
        .gnt_o   (gnt)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t          st_q;
        logic [ANGLE_W-1:0] pend_q;
        logic [ANGLE_W-1:0] hold_q;
        logic [ANGLE_W-1:0] tgt_q;
        logic               hold_v_q;
        logic               upd_q;
        logic               abt_q;
        logic               busy_q;
        logic               done_q;
        logic               err_q;
        logic [TO_W-1:0]    timer_q;
        logic [TO_W-1:0]    timer_inc;
        logic [ANGLE_W-1:0] new_tgt;
        logic [ANGLE_W-1:0] cur;
        logic [ANGLE_W-1:0] eff_tgt;
        logic               wr;
        logic               fin;
        logic               expire;
        logic               skip;

        assign wr        = tgt_wr_i[i];
        assign fin       = angle_done_i[i];
        assign new_tgt   = tgt_angle_i[ANGLE_W*i +: ANGLE_W];
        assign cur       = cur_angle_i[ANGLE_W*i +: ANGLE_W];
        assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
        assign expire    = (timeout_cycles_i != '0)
                        && (timer_q == timeout_cycles_i);
        // A write arriving in the grant cycle is the newest target
        assign eff_tgt   = wr ? new_tgt : pend_q;
        assign skip      = circ_dist(eff_tgt, cur)
                        <= (ANGLE_W+1)'(TOL);

        assign pend_v[i] = (st_q == PENDING);
        assign run_v[i]  = (st_q == ACTIVE) || (st_q == ABORTING);

        // Channel sequencing FSM with registered outputs
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                st_q     <= IDLE;
                pend_q   <= '0;
                hold_q   <= '0;
                hold_v_q <= 1'b0;
                tgt_q    <= '0;
                timer_q  <= '0;
                upd_q    <= 1'b0;
                abt_q    <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                upd_q  <= 1'b0;
                done_q <= 1'b0;
                if (err_clr_i) begin
                    err_q <= 1'b0;
                end
                unique case (st_q)
                    IDLE: begin
                        if (wr && !abort_all_i) begin
                            st_q   <= PENDING;
                            pend_q <= new_tgt;
                            busy_q <= 1'b1;
                        end
                    end
                    PENDING: begin
                        if (abort_all_i) begin
                            st_q   <= IDLE;
                            busy_q <= 1'b0;
                        end else if (gnt[i]) begin
                            if (skip) begin
                                st_q   <= IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                st_q    <= ACTIVE;
                                tgt_q   <= eff_tgt;
                                upd_q   <= 1'b1;
                                timer_q <= '0;
                            end
                        end else if (wr) begin
                            pend_q <= new_tgt;
                        end
                    end
                    ACTIVE: begin
                        if (abort_all_i) begin
                            // A move finishing as the abort lands
                            // needs no abort handshake
                            hold_v_q <= 1'b0;
                            timer_q  <= '0;
                            if (fin) begin
                                st_q   <= IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                st_q  <= ABORTING;
                                abt_q <= 1'b1;
                            end
                        end else if (fin) begin
                            done_q   <= 1'b1;
                            hold_v_q <= 1'b0;
                            timer_q  <= '0;
                            if (wr || hold_v_q) begin
                                st_q   <= PENDING;
                                pend_q <= wr ? new_tgt : hold_q;
                            end else begin
                                st_q   <= IDLE;
                                busy_q <= 1'b0;
                            end
                        end else if (expire) begin
                            st_q     <= ABORTING;
                            abt_q    <= 1'b1;
                            err_q    <= 1'b1;
                            timer_q  <= '0;
                            hold_v_q <= 1'b0;
                        end else begin
                            timer_q <= timer_inc;
                            if (wr) begin
                                hold_q   <= new_tgt;
                                hold_v_q <= 1'b1;
                            end
                        end
                    end
                    ABORTING: begin
                        if (fin || expire) begin
                            st_q     <= IDLE;
                            abt_q    <= 1'b0;
                            busy_q   <= 1'b0;
                            hold_v_q <= 1'b0;
                            timer_q  <= '0;
                        end else begin
                            timer_q <= timer_inc;
                        end
                    end
                endcase
            end
        end

        assign target_angle_o[ANGLE_W*i +: ANGLE_W] = tgt_q;
        assign angle_update_o[i] = upd_q;
        assign abort_angle_o[i]  = abt_q;
        assign busy_o[i]         = busy_q;
        assign done_evt_o[i]     = done_q;
        assign timeout_err_o[i]  = err_q;
    end

endmodule

// File: tb/tb_rotation_scheduler.sv
// Bench for rotation_scheduler: directed scenarios plus a random run
// scored against a per-wheel job model.
module tb_rotation_scheduler;

    localparam int NCH  = 4;
    localparam int AW   = 12;
    localparam int TOL  = 5;
    localparam int MAXA = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [NCH-1:0]    tgt_wr;
    logic [AW*NCH-1:0] tgt_angle;
    logic [AW*NCH-1:0] cur_angle;
    logic [23:0]       timeout_cycles;
    logic              abort_all;
    logic              err_clr;
    logic [NCH-1:0]    angle_done;
    logic [AW*NCH-1:0] target_angle;
    logic [NCH-1:0]    angle_update;
    logic [NCH-1:0]    abort_angle;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done_evt;
    logic [NCH-1:0]    timeout_err;

    int errors = 0;
    int checks = 0;

    rotation_scheduler dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .tgt_wr_i         (tgt_wr),
        .tgt_angle_i      (tgt_angle),
        .cur_angle_i      (cur_angle),
        .timeout_cycles_i (timeout_cycles),
        .abort_all_i      (abort_all),
        .err_clr_i        (err_clr),
        .angle_done_i     (angle_done),
        .target_angle_o   (target_angle),
        .angle_update_o   (angle_update),
        .abort_angle_o    (abort_angle),
        .busy_o           (busy),
        .done_evt_o       (done_evt),
        .timeout_err_o    (timeout_err)
    );

    // Job model: a wheel either waits for a slot, moves, or is stopping.
    bit                m_wait [NCH];
    bit                m_move [NCH];
    bit                m_stop [NCH];
    bit                m_nv   [NCH];
    int                m_job  [NCH];
    int                m_next [NCH];
    int                m_age  [NCH];
    int                m_ptr;
    logic [AW*NCH-1:0] m_tgt;
    logic [NCH-1:0]    m_upd;
    logic [NCH-1:0]    m_done;
    logic [NCH-1:0]    m_err;

    function automatic int cdist(int t, int c);
        int d;
        d = (t - c) & 4095;
        return (d <= 2048) ? d : 4096 - d;
    endfunction

    function automatic logic [NCH-1:0] m_busy();
        logic [NCH-1:0] b;
        for (int c = 0; c < NCH; c++) b[c] = m_wait[c] | m_move[c] | m_stop[c];
        return b;
    endfunction

    function automatic logic [NCH-1:0] m_abort();
        logic [NCH-1:0] b;
        for (int c = 0; c < NCH; c++) b[c] = m_stop[c];
        return b;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_wait[c] = 0; m_move[c] = 0; m_stop[c] = 0; m_nv[c] = 0;
            m_job[c] = 0; m_next[c] = 0; m_age[c] = 0;
        end
        m_ptr = 0; m_tgt = '0; m_upd = '0; m_done = '0; m_err = '0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int busy_slots, g, to, nt, ca;
        bit w, dn, exp_hit;
        busy_slots = 0;
        for (int c = 0; c < NCH; c++) if (m_move[c] || m_stop[c]) busy_slots++;
        g = -1;
        if (!abort_all && busy_slots < MAXA)
            for (int k = 0; k < NCH; k++)
                if (g < 0 && m_wait[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
        if (g >= 0) m_ptr = (g + 1) % NCH;
        m_upd = '0; m_done = '0;
        if (err_clr) m_err = '0;
        to = int'(timeout_cycles);
        for (int c = 0; c < NCH; c++) begin
            w  = tgt_wr[c];
            dn = angle_done[c];
            nt = int'(tgt_angle[c*AW +: AW]);
            ca = int'(cur_angle[c*AW +: AW]);
            exp_hit = (to != 0) && (m_age[c] == to);
            if (m_wait[c]) begin
                if (abort_all) m_wait[c] = 0;
                else begin
                    if (w) m_job[c] = nt;
                    if (g == c) begin
                        m_wait[c] = 0;
                        if (cdist(m_job[c], ca) <= TOL) m_done[c] = 1;
                        else begin
                            m_move[c] = 1; m_upd[c] = 1; m_age[c] = 0;
                            m_tgt[c*AW +: AW] = 12'(m_job[c]);
                        end
                    end
                end
            end else if (m_move[c]) begin
                if (abort_all) begin
                    m_move[c] = 0; m_nv[c] = 0; m_age[c] = 0;
                    if (!dn) m_stop[c] = 1;
                end else if (dn) begin
                    m_move[c] = 0; m_done[c] = 1;
                    if (w) begin m_wait[c] = 1; m_job[c] = nt; end
                    else if (m_nv[c]) begin m_wait[c] = 1; m_job[c] = m_next[c]; end
                    m_nv[c] = 0;
                end else if (exp_hit) begin
                    m_move[c] = 0; m_stop[c] = 1; m_err[c] = 1;
                    m_age[c] = 0; m_nv[c] = 0;
                end else begin
                    m_age[c]++;
                    if (w) begin m_next[c] = nt; m_nv[c] = 1; end
                end
            end else if (m_stop[c]) begin
                if (dn || exp_hit) begin m_stop[c] = 0; m_age[c] = 0; end
                else m_age[c]++;
            end else if (w && !abort_all) begin
                m_wait[c] = 1; m_job[c] = nt;
            end
        end
    endtask

    task automatic clear_strobes();
        tgt_wr = '0; angle_done = '0; abort_all = 1'b0; err_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        clear_strobes();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_strobes();
        model_reset();
        #1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && busy !== '0; n++) begin
            angle_done = '1;
            tick();
        end
    endtask

    task automatic test_reset();
        tgt_angle = '0; cur_angle = '0; timeout_cycles = '0;
        do_reset();
        checks++; if (target_angle !== '0) begin errors++; $display("FAIL reset_target: got %h want 0", target_angle); end
        checks++; if (angle_update !== '0) begin errors++; $display("FAIL reset_update: got %b want 0", angle_update); end
        checks++; if (abort_angle !== '0) begin errors++; $display("FAIL reset_abort: got %b want 0", abort_angle); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done_evt !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", done_evt); end
        checks++; if (timeout_err !== '0) begin errors++; $display("FAIL reset_err: got %b want 0", timeout_err); end
    endtask

    task automatic test_single_move();
        do_reset();
        cur_angle = '0;
        tgt_angle[11:0] = 12'd1000; tgt_wr = 4'b0001;
        tick();
        checks++; if (busy !== 4'b0001 || angle_update !== 4'b0000) begin errors++; $display("FAIL single_pending: busy %b upd %b want 0001 0000", busy, angle_update); end
        tick();
        checks++; if (angle_update !== 4'b0001) begin errors++; $display("FAIL single_update: got %b want 0001", angle_update); end
        checks++; if (target_angle[11:0] !== 12'd1000) begin errors++; $display("FAIL single_target: got %0d want 1000", target_angle[11:0]); end
        tick();
        checks++; if (angle_update !== 4'b0000) begin errors++; $display("FAIL single_pulse: got %b want 0000", angle_update); end
        angle_done = 4'b0001;
        tick();
        checks++; if (done_evt !== 4'b0001 || busy !== 4'b0000) begin errors++; $display("FAIL single_done: done %b busy %b want 0001 0000", done_evt, busy); end
        tick();
        checks++; if (done_evt !== 4'b0000) begin errors++; $display("FAIL single_done_pulse: got %b want 0000", done_evt); end
    endtask

    task automatic test_max_active();
        int bad;
        do_reset();
        cur_angle = '0;
        for (int c = 0; c < NCH; c++) tgt_angle[c*AW +: AW] = 12'(1000 + 500 * c);
        tgt_wr = 4'b1111;
        tick();
        checks++; if (busy !== 4'b1111) begin errors++; $display("FAIL cap_pending: got %b want 1111", busy); end
        tick();
        checks++; if (angle_update !== 4'b0001) begin errors++; $display("FAIL cap_grant0: got %b want 0001", angle_update); end
        tick();
        checks++; if (angle_update !== 4'b0010) begin errors++; $display("FAIL cap_grant1: got %b want 0010", angle_update); end
        bad = 0;
        repeat (4) begin tick(); if (angle_update !== 4'b0000) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL cap_held: %0d cycles with a third grant, want 0", bad); end
        angle_done = 4'b0001;
        tick();
        checks++; if (done_evt !== 4'b0001 || angle_update !== 4'b0000) begin errors++; $display("FAIL cap_done0: done %b upd %b want 0001 0000", done_evt, angle_update); end
        tick();
        checks++; if (angle_update !== 4'b0100) begin errors++; $display("FAIL cap_grant2: got %b want 0100", angle_update); end
        checks++; if (target_angle[35:24] !== 12'd2000) begin errors++; $display("FAIL cap_target2: got %0d want 2000", target_angle[35:24]); end
        drain();
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL cap_drain: busy %b want 0000", busy); end
    endtask

    task automatic test_skip_tolerance();
        int  tt [7] = '{4094, 4093, 4092, 7, 8, 2, 2050};
        bit  mv [7] = '{0, 0, 1, 0, 1, 0, 1};
        do_reset();
        cur_angle[11:0] = 12'd2;
        for (int e = 0; e < 7; e++) begin
            tgt_angle[11:0] = 12'(tt[e]); tgt_wr = 4'b0001;
            tick();
            tick();
            checks++; if (angle_update[0] !== mv[e] || done_evt[0] !== !mv[e]) begin errors++; $display("FAIL skip_%0d: upd %b done %b want %b %b", tt[e], angle_update[0], done_evt[0], mv[e], !mv[e]); end
            if (mv[e]) begin
                checks++; if (target_angle[11:0] !== 12'(tt[e])) begin errors++; $display("FAIL skip_tgt_%0d: got %0d", tt[e], target_angle[11:0]); end
                angle_done = 4'b0001;
            end
            tick();
            checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL skip_idle_%0d: busy %b want 0000", tt[e], busy); end
        end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        timeout_cycles = 24'd100;
        cur_angle = '0;
        tgt_angle[11:0] = 12'd3000; tgt_wr = 4'b0001;
        tick();
        tick();
        checks++; if (angle_update !== 4'b0001) begin errors++; $display("FAIL to_start: got %b want 0001", angle_update); end
        bad = 0;
        repeat (100) begin tick(); if (abort_angle !== 4'b0000) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL to_early: %0d early abort cycles, want 0", bad); end
        tick();
        checks++; if (abort_angle !== 4'b0001 || timeout_err !== 4'b0001) begin errors++; $display("FAIL to_fire: abort %b err %b want 0001 0001", abort_angle, timeout_err); end
        angle_done = 4'b0001;
        tick();
        checks++; if (abort_angle !== 4'b0000 || busy !== 4'b0000 || done_evt !== 4'b0000) begin errors++; $display("FAIL to_exit: abort %b busy %b done %b want 0", abort_angle, busy, done_evt); end
        checks++; if (timeout_err !== 4'b0001) begin errors++; $display("FAIL to_sticky: got %b want 0001", timeout_err); end
        err_clr = 1'b1;
        tick();
        checks++; if (timeout_err !== 4'b0000) begin errors++; $display("FAIL to_clear: got %b want 0000", timeout_err); end
        timeout_cycles = '0;
    endtask

    task automatic test_done_with_write();
        do_reset();
        cur_angle = '0;
        tgt_angle[11:0] = 12'd1000; tgt_wr = 4'b0001;
        tick();
        tick();
        tick();
        tgt_angle[11:0] = 12'd2000; tgt_wr = 4'b0001; angle_done = 4'b0001;
        tick();
        checks++; if (done_evt !== 4'b0001 || busy !== 4'b0001 || angle_update !== 4'b0000) begin errors++; $display("FAIL redo_done: done %b busy %b upd %b want 0001 0001 0000", done_evt, busy, angle_update); end
        tick();
        checks++; if (angle_update !== 4'b0001 || target_angle[11:0] !== 12'd2000) begin errors++; $display("FAIL redo_grant: upd %b tgt %0d want 0001 2000", angle_update, target_angle[11:0]); end
        angle_done = 4'b0001;
        tick();
        checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL redo_idle: busy %b want 0000", busy); end
    endtask

    task automatic test_abort_all();
        do_reset();
        timeout_cycles = 24'd1000;
        cur_angle = '0;
        tgt_angle[11:0] = 12'd1000; tgt_angle[23:12] = 12'd1500; tgt_wr = 4'b0011;
        tick();
        tick();
        checks++; if (angle_update !== 4'b0001) begin errors++; $display("FAIL abort_setup: got %b want 0001", angle_update); end
        abort_all = 1'b1; tgt_wr = 4'b0010; tgt_angle[23:12] = 12'd3000;
        tick();
        checks++; if (abort_angle !== 4'b0001 || busy !== 4'b0001) begin errors++; $display("FAIL abort_hit: abort %b busy %b want 0001 0001", abort_angle, busy); end
        repeat (5) tick();
        checks++; if (abort_angle !== 4'b0001 || angle_update !== 4'b0000 || timeout_err !== 4'b0000) begin errors++; $display("FAIL abort_hold: abort %b upd %b err %b", abort_angle, angle_update, timeout_err); end
        angle_done = 4'b0001;
        tick();
        checks++; if (abort_angle !== 4'b0000 || busy !== 4'b0000 || done_evt !== 4'b0000 || timeout_err !== 4'b0000) begin errors++; $display("FAIL abort_exit: abort %b busy %b done %b err %b want 0", abort_angle, busy, done_evt, timeout_err); end
        timeout_cycles = '0;
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        cur_angle = '0;
        tgt_angle[11:0] = 12'd900; tgt_wr = 4'b0001;
        tick();
        tick();
        #3 reset_n = 1'b0;
        #1;
        checks++; if (busy !== '0 || target_angle !== '0 || angle_update !== '0) begin errors++; $display("FAIL midreset: busy %b tgt %h upd %b want 0", busy, target_angle, angle_update); end
        do_reset();
    endtask

    task automatic test_random();
        int to_tab [4] = '{0, 4, 12, 30};
        int cv, tv;
        do_reset();
        for (int c = 0; c < NCH; c++) cur_angle[c*AW +: AW] = 12'($urandom_range(0, 4095));
        for (int seg = 0; seg < 4; seg++) begin
            timeout_cycles = 24'(to_tab[seg]);
            for (int n = 0; n < 800; n++) begin
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(0, 19) == 0) cur_angle[c*AW +: AW] = 12'($urandom_range(0, 4095));
                    cv = int'(cur_angle[c*AW +: AW]);
                    tv = ($urandom_range(0, 2) == 0) ? (cv + int'($urandom_range(0, 14)) - 7) & 4095 : int'($urandom_range(0, 4095));
                    tgt_angle[c*AW +: AW] = 12'(tv);
                    tgt_wr[c] = ($urandom_range(0, 5) == 0);
                    angle_done[c] = ($urandom_range(0, 6) == 0);
                end
                abort_all = ($urandom_range(0, 199) == 0);
                err_clr = ($urandom_range(0, 49) == 0);
                tick();
                checks++; if (target_angle !== m_tgt) begin errors++; $display("FAIL rnd_target seg%0d n%0d: got %h want %h", seg, n, target_angle, m_tgt); end
                checks++; if (angle_update !== m_upd) begin errors++; $display("FAIL rnd_update seg%0d n%0d: got %b want %b", seg, n, angle_update, m_upd); end
                checks++; if (abort_angle !== m_abort()) begin errors++; $display("FAIL rnd_abort seg%0d n%0d: got %b want %b", seg, n, abort_angle, m_abort()); end
                checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rnd_busy seg%0d n%0d: got %b want %b", seg, n, busy, m_busy()); end
                checks++; if (done_evt !== m_done) begin errors++; $display("FAIL rnd_done seg%0d n%0d: got %b want %b", seg, n, done_evt, m_done); end
                checks++; if (timeout_err !== m_err) begin errors++; $display("FAIL rnd_err seg%0d n%0d: got %b want %b", seg, n, timeout_err, m_err); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_max_active();
        test_skip_tolerance();
        test_timeout();
        test_done_with_write();
        test_abort_all();
        test_reset_mid_move();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
